div_seq: RTL and testbench

//  Iterative radix-2 restoring divider for the MIPS Hi/Lo unit. Executes DIV/DIVU

---
 rtl/div_seq_pkg.sv | 26 ++
 rtl/div_step.sv | 41 ++++
 rtl/div_seq.sv | 165 ++++++++++++++++
 tb/tb_div_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_pkg
//  Description : Shared definitions for the sequential Hi/Lo divider.
//                Holds the FSM state encoding, the default operand width and
//                a helper that sizes the iteration counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_RUN  = 2'd1;
    localparam state_t c_SIGN = 2'd2;
    localparam state_t c_DONE = 2'd3;

    // Counter must be able to represent WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring division step.
//                Shifts the next dividend bit into the partial remainder and
//                subtracts the divisor when it fits.
//  Ports       : i_rem       partial remainder in (WIDTH)
//                i_dvd_bit   next dividend bit, MSB first
//                i_divisor   divisor magnitude (WIDTH)
//                o_rem       partial remainder out (WIDTH)
//                o_q_bit     quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    // The shifted remainder is kept WIDTH+1 bits wide: with a divisor above
    // 2^(WIDTH-1) the shifted value can exceed WIDTH bits before the subtract.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_shift = {i_rem, i_dvd_bit};
        o_q_bit = (w_shift >= {1'b0, i_divisor});
        // When the divisor fits, the true difference is below the divisor and
        // therefore fits in WIDTH bits, so modular subtraction is exact.
        w_diff  = w_shift[WIDTH-1:0] - i_divisor;
        o_rem   = o_q_bit ? w_diff : w_shift[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Iterative radix-2 restoring divider for the Hi/Lo unit.
//                Executes DIV/DIVU in WIDTH steps; quotient goes to Lo,
//                remainder to Hi. Divide by zero completes immediately and
//                leaves the previous results untouched.
//  Ports       : clk          rising-edge clock
//                rst          synchronous active-high reset
//                start        launch a division (only honoured when idle)
//                is_signed    1 = DIV, 0 = DIVU, sampled with start
//                a, b         dividend / divisor, sampled with start
//                busy         high while a division is in flight
//                done         one-cycle completion pulse
//                quotient     quotient, held until the next completion
//                remainder    remainder, held until the next completion
//                div_by_zero  pulses with done when b was zero
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;      // dividend shifts out MSB-first, quotient shifts in
    logic [WIDTH-1:0]   r_dvs;
    logic               r_sq;
    logic               r_sr;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_q;
    logic               w_b_zero;

    // Magnitudes: -2^(WIDTH-1) negates to itself, which reads correctly as
    // an unsigned WIDTH-bit magnitude.
    always_comb begin
        w_a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
        w_b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
        w_b_zero = (b == '0);
    end

    div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_q)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = w_b_zero ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_SIGN;
                end
            end
            c_SIGN:  w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_sq        <= 1'b0;
            r_sr        <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != c_IDLE);
            r_done <= (w_state_nxt == c_DONE);
            r_dbz  <= (r_state == c_IDLE) && start && w_b_zero;

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_rem <= '0;
                        r_dvd <= w_a_mag;
                        r_dvs <= w_b_mag;
                        r_sq  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sr  <= is_signed & a[WIDTH-1];
                    end
                end
                c_RUN: begin
                    r_rem <= w_step_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_step_q};
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                c_SIGN: begin
                    r_quotient  <= r_sq ? -r_dvd : r_dvd;
                    r_remainder <= r_sr ? -r_rem : r_rem;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Self-checking bench for div_seq (WIDTH=32). A timeline
//                model computes expected results with plain integer
//                division; directed vectors pin that model with literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    div_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division, remainder follows dividend.
    function automatic void ref_div(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic s, output logic [WIDTH-1:0] q,
                                    output logic [WIDTH-1:0] r);
        longint sx;
        longint sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = WIDTH'(sx / sy);
            r  = WIDTH'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // ------------------------------------------------------------------
    // Timeline model: m_left counts edges until the unit is idle again;
    // done is the last cycle of that window.
    // ------------------------------------------------------------------
    int               m_left = 0;
    logic             m_pdbz = 1'b0;
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_r = '0;
    logic [WIDTH-1:0] m_nq = '0;
    logic [WIDTH-1:0] m_nr = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_pdbz = 1'b0;
            m_q    = '0;
            m_r    = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1 && !m_pdbz) begin
                m_q = m_nq;
                m_r = m_nr;
            end
        end else if (start) begin
            m_pdbz = (b == '0);
            if (b != '0) ref_div(a, b, is_signed, m_nq, m_nr);
            m_left = (b == '0) ? 1 : WIDTH + 2;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",        WIDTH'(busy),        WIDTH'(m_left != 0));
            check("done",        WIDTH'(done),        WIDTH'(m_left == 1));
            check("div_by_zero", WIDTH'(div_by_zero), WIDTH'((m_left == 1) && m_pdbz));
            check("quotient",    quotient,            m_q);
            check("remainder",   remainder,           m_r);
        end
    end

    // Wait for done, sampling 2 time units after each edge; n counts edges
    // after the accepting edge.
    task automatic wait_done(inout int n);
        while (!done && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Issue a division from idle, check latency and literal results, then
    // leave the bench idle in the cycle after done.
    task automatic run_div(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic ts, input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic edbz, input int elat);
        int n;
        start = 1'b1; a = ta; b = tb; is_signed = ts;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        wait_done(n);
        check({name, "_lat"}, n,         elat);
        check({name, "_q"},   quotient,  eq);
        check({name, "_r"},   remainder, er);
        check({name, "_dbz"}, WIDTH'(div_by_zero), WIDTH'(edbz));
        @(posedge clk); #2;
    endtask

    initial begin : stim
        int n;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        @(posedge clk); #2;
        chk_en = 1'b1;
        check("rst_busy", WIDTH'(busy), '0);
        check("rst_done", WIDTH'(done), '0);
        check("rst_q",    quotient,     '0);
        check("rst_r",    remainder,    '0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        // Basic unsigned, then divide by zero leaving 14/2 in place.
        run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, WIDTH + 1);
        run_div("dbz",    32'd55,  32'd0, 1'b1, 32'd14, 32'd2, 1'b1, 0);

        // Signed cases: remainder sign follows dividend.
        run_div("s_m7_2",   32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, WIDTH + 1);
        run_div("s_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, WIDTH + 1);
        run_div("s_m100_m7",32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 1'b0, WIDTH + 1);

        // Overflow corner and the same bits unsigned.
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, WIDTH + 1);
        run_div("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0, WIDTH + 1);

        // Divisor above 2^(W-1), and dividend smaller than divisor.
        run_div("u_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0, WIDTH + 1);
        run_div("u_small", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, WIDTH + 1);

        // Start while busy is ignored; back-to-back start right after done.
        start = 1'b1; a = 32'd100; b = 32'd7; is_signed = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        repeat (4) begin @(posedge clk); #2; n++; end
        start = 1'b1; a = 32'd9; b = 32'd3;
        @(posedge clk); #2;
        n++;
        start = 1'b0;
        wait_done(n);
        check("busy_ign_lat", n,         WIDTH + 1);
        check("busy_ign_q",   quotient,  32'd14);
        check("busy_ign_r",   remainder, 32'd2);
        // Start asserted during the done cycle must be ignored too.
        start = 1'b1; a = 32'd8; b = 32'd0;
        @(posedge clk); #2;
        start = 1'b0;
        check("done_ign_busy", WIDTH'(busy), '0);
        run_div("b2b_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, WIDTH + 1);

        // Reset in the middle of a division.
        start = 1'b1; a = 32'd100; b = 32'd7; is_signed = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("abort_busy", WIDTH'(busy), '0);
        check("abort_done", WIDTH'(done), '0);
        check("abort_q",    quotient,     '0);
        check("abort_r",    remainder,    '0);
        repeat (40) begin @(posedge clk); #2; end
        run_div("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, WIDTH + 1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
